// File: rtl/sha1_pkg.sv
// Shared constants, state encoding and byte-lane helper for the SHA-1 front end.
package sha1_pkg;

  localparam logic [159:0] H_INIT =
    {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476, 32'hc3d2e1f0};

  localparam int          BLOCK_BYTES = 64;
  localparam int          LEN_OFFSET  = 56;
  localparam logic [7:0]  PAD_BYTE    = 8'h80;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_PAD,
    ST_EMIT,
    ST_LENBLK
  } padder_state_t;

  // Byte i lives in word i/4, big-endian inside the word: lsb = 32*(i/4) + 8*(3 - i%4).
  function automatic logic [8:0] byte_lsb(input logic [5:0] idx);
    return {idx[5:2], ~idx[1:0], 3'b000};
  endfunction

endpackage

// File: rtl/sha1_padder_if.sv
// Byte-input and block-output handshakes between message source, padder and SHA-1 core.
interface sha1_padder_if;
  import sha1_pkg::*;

  logic                       in_valid;
  logic [7:0]                 in_data;
  logic                       in_last;
  logic                       in_keep;
  logic                       in_ready;
  logic                       blk_valid;
  logic                       blk_ready;
  logic [BLOCK_BYTES*8-1:0]   blk_data;
  logic                       blk_first;
  logic                       blk_last;

  modport master (
    output in_valid, in_data, in_last, in_keep, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_first, blk_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_keep, blk_ready,
    output in_ready, blk_valid, blk_data, blk_first, blk_last
  );
endinterface

// File: rtl/sha1_len_counter.sv
// Message bit-length accumulator: +8 per data byte, cleared after a message's last block.
module sha1_len_counter #(
  parameter int LEN_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_add8,
  input  logic             i_clear,
  output logic [LEN_W-1:0] o_len
);

  logic [LEN_W-1:0] r_len;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_len <= '0;
    else if (i_clear)  r_len <= '0;
    else if (i_add8)   r_len <= r_len + LEN_W'(8);
  end

  assign o_len = r_len;

endmodule

// File: rtl/sha1_padder.sv
// Assembles message bytes into 512-bit SHA-1 blocks and appends 0x80/zero/length padding.
module sha1_padder
  import sha1_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  sha1_padder_if.slave bus
);

  padder_state_t r_state, w_state_next;
  logic [511:0]  r_buf, w_buf_next;
  logic [5:0]    r_pos, w_pos_next;
  logic          r_last, w_last_next;
  logic          r_first, w_first_next;
  logic          r_len_pend, w_len_pend_next;
  logic          r_pad_pend, w_pad_pend_next;
  logic          w_add8, w_clear;
  logic [LEN_W-1:0] w_len;

  function automatic logic [511:0] put_byte(input logic [511:0] b, input logic [5:0] idx,
                                            input logic [7:0] d);
    logic [511:0] r;
    r = b;
    r[byte_lsb(idx) +: 8] = d;
    return r;
  endfunction

  function automatic logic [511:0] pad_from(input logic [511:0] b, input logic [5:0] idx);
    logic [511:0] r;
    r = b;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (6'(i) == idx)     r[byte_lsb(6'(i)) +: 8] = PAD_BYTE;
      else if (6'(i) > idx) r[byte_lsb(6'(i)) +: 8] = 8'h00;
    end
    return r;
  endfunction

  function automatic logic [511:0] put_len(input logic [511:0] b, input logic [63:0] len);
    logic [511:0] r;
    r = b;
    r[32*(LEN_OFFSET/4)     +: 32] = len[63:32];
    r[32*(LEN_OFFSET/4 + 1) +: 32] = len[31:0];
    return r;
  endfunction

  sha1_len_counter #(.LEN_W(LEN_W)) u_len (
    .clk     (clk),
    .rst     (rst),
    .i_add8  (w_add8),
    .i_clear (w_clear),
    .o_len   (w_len)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_FILL;
      r_buf      <= '0;
      r_pos      <= '0;
      r_last     <= 1'b0;
      r_first    <= 1'b1;
      r_len_pend <= 1'b0;
      r_pad_pend <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_buf      <= w_buf_next;
      r_pos      <= w_pos_next;
      r_last     <= w_last_next;
      r_first    <= w_first_next;
      r_len_pend <= w_len_pend_next;
      r_pad_pend <= w_pad_pend_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_buf_next      = r_buf;
    w_pos_next      = r_pos;
    w_last_next     = r_last;
    w_first_next    = r_first;
    w_len_pend_next = r_len_pend;
    w_pad_pend_next = r_pad_pend;
    w_add8          = 1'b0;
    w_clear         = 1'b0;
    bus.in_ready    = 1'b0;
    bus.blk_valid   = 1'b0;

    case (r_state)
      ST_FILL: begin
        bus.in_ready = rst;
        if (bus.in_valid) begin
          if (bus.in_keep) begin
            w_buf_next = put_byte(r_buf, r_pos, bus.in_data);
            w_pos_next = r_pos + 6'd1;
            w_add8     = 1'b1;
            // A full block always goes out first; a same-beat terminator is replayed as PAD.
            if (r_pos == 6'd63) begin
              w_state_next    = ST_EMIT;
              w_last_next     = 1'b0;
              w_pad_pend_next = bus.in_last;
            end else if (bus.in_last) begin
              w_state_next = ST_PAD;
            end
          end else if (bus.in_last) begin
            w_state_next = ST_PAD;
          end
        end
      end

      ST_PAD: begin
        w_buf_next   = pad_from(r_buf, r_pos);
        w_state_next = ST_EMIT;
        if (r_pos <= 6'(LEN_OFFSET - 1)) begin
          w_buf_next  = put_len(pad_from(r_buf, r_pos), w_len);
          w_last_next = 1'b1;
        end else begin
          w_len_pend_next = 1'b1;
          w_last_next     = 1'b0;
        end
      end

      ST_EMIT: begin
        bus.blk_valid = 1'b1;
        if (bus.blk_ready) begin
          if (r_len_pend) begin
            w_len_pend_next = 1'b0;
            w_first_next    = 1'b0;
            w_state_next    = ST_LENBLK;
          end else if (r_last) begin
            w_clear      = 1'b1;
            w_pos_next   = '0;
            w_first_next = 1'b1;
            w_last_next  = 1'b0;
            w_state_next = ST_FILL;
          end else begin
            w_first_next = 1'b0;
            if (r_pad_pend) begin
              w_pad_pend_next = 1'b0;
              w_state_next    = ST_PAD;
            end else begin
              w_state_next = ST_FILL;
            end
          end
        end
      end

      ST_LENBLK: begin
        w_buf_next   = put_len('0, w_len);
        w_last_next  = 1'b1;
        w_state_next = ST_EMIT;
      end

      default: w_state_next = ST_FILL;
    endcase
  end

  // Buffer holds leftovers from the previous block while filling, so only show it in EMIT.
  assign bus.blk_data  = (r_state == ST_EMIT) ? r_buf : '0;
  assign bus.blk_first = r_first;
  assign bus.blk_last  = r_last;

endmodule

// File: doc/sha1_padder.md
# sha1_padder

Byte-stream front end for the SHA-1 compression core. It accepts message bytes over a valid/ready handshake, assembles 512-bit blocks and counts the message length. On end of message it appends the SHA-1 padding (0x80, zeros, 64-bit big-endian bit length). It presents each finished block, with first/last markers, to the core over a second valid/ready handshake.

## Interface
- `LEN_W`, 64: width of the bit-length counter; fixed at 64 for SHA-1, with wrap mod 2^64.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `in_valid` input 1: byte (or terminator) present.
- `in_data` input 8: message byte.
- `in_last` input 1: this beat ends the message.
- `in_keep` input 1: `in_data` is real data. A beat with `in_last=1, in_keep=0` is a zero-data terminator, used for empty messages or when the last byte was already sent. `in_keep=0` with `in_last=0` is ignored (accepted, no effect).
- `in_ready` output 1: padder accepts an input beat this cycle.
- `blk_valid` output 1: `blk_data` holds a complete block.
- `blk_ready` input 1: core takes the block.
- `blk_data` output 512: block. Word k = `blk_data[32k+31:32k]` maps to W[k]. Byte i of the block sits in word i/4, bits `[32(i/4)+8(3-i%4)+7 -: 8]` (big-endian within each word).
- `blk_first` output 1: block is the first of its message; the core reloads its initial H.
- `blk_last` output 1: block is the final (padded) block of its message.

## Operation
- States: FILL, PAD, EMIT, LENBLK.
- **FILL:** `in_ready=1`. Each accepted beat with `in_keep=1` writes the byte at position `pos`, increments `pos` (6-bit) and adds 8 to `len`.
  - `pos` wrapping 63→0 → EMIT (`blk_last=0`).
  - Accepted `in_last` → PAD, taking effect after any byte carried on the same beat.
  - If a data byte with `in_last=1` fills position 63, the block is emitted first, then PAD runs with `pos=0`.
- **PAD**, one cycle, `in_ready=0`:
  - Write 0x80 at `pos` and zero at bytes `pos+1..63`.
  - If `pos ≤ 55`: write `len` into bytes 56..63 (word14 = `len[63:32]`, word15 = `len[31:0]`), set last → EMIT.
  - Otherwise → EMIT with last=0, and a length block follows.
- **EMIT:** `blk_valid=1`, `in_ready=0`. `blk_data`, `blk_first` and `blk_last` are held stable until `blk_ready`. On handshake:
  - If a length block is pending → LENBLK.
  - If last → clear `len` and `pos`, set first-pending → FILL.
  - Otherwise → FILL (after a full data block) or PAD (if a full block was closed by `in_last`).
- **LENBLK**, one cycle: block = zeros with `len` in bytes 56..63, last=1 → EMIT.
- `blk_first` = 1 on the first emitted block after reset or after a last block; otherwise 0.
- Buffer bytes not yet written in a block are don't-care until PAD overwrites them. `blk_data` never exposes stale bytes from a prior block.

## Timing
- Reset values: `in_ready=0` during reset, 1 in the first cycle after release (FILL). `blk_valid=0`, `blk_data=0`, `blk_first=1`, `blk_last=0`, `len=0`, `pos=0`.
- Throughput in FILL: 1 byte/cycle, so 64 cycles per full block plus EMIT cycles.
- Latency from handshake of the last input beat to `blk_valid`:
  - 2 cycles if `pos ≤ 55` at termination (PAD, then EMIT).
  - Otherwise 2 cycles to the padding block, then 2 cycles after its handshake to the length block.
- `blk_valid` never drops without `blk_ready`. `in_ready` and `blk_valid` are never both 1.
- `blk_ready` high while `blk_valid=0` is ignored.
- Reset mid-message or mid-EMIT discards all state immediately and asynchronously, with no partial block emitted.

## Structure
- Package `sha1_pkg`:
  - Initial H constants 67452301/efcdab89/98badcfe/10325476/c3d2e1f0.
  - `BLOCK_BYTES=64`, `LEN_OFFSET=56`, `PAD_BYTE=8'h80`.
  - State enum `padder_state_t`.
- Sub-module `sha1_len_counter`: 64-bit bit-length accumulator with add-8 and clear, wrapping mod 2^64.
- Byte insertion and padding mask are combinational functions in the main module.

## Test plan
- "abc" (0x61,0x62,0x63, last on 0x63) → one block: word0=61626380, words1–14=0, word15=00000018, first=last=1.
- Empty message (single beat `in_last=1, in_keep=0`) → one block: word0=80000000, all others 0, first=last=1.
- 55 bytes → one block with length 0x1B8 in word15. 56 bytes → two blocks: block 1 with 0x80 at byte 56 and no length, first=1/last=0; block 2 all zero except word15=000001C0, first=0/last=1.
- 64 bytes, last on byte 63 → data block, then word0=80000000, word15=00000200, last=1.
- `blk_ready` held low 10 cycles during EMIT → `blk_data` and flags stable, `in_ready=0`. Two back-to-back messages → `blk_first` reasserted on the second message's first block.
- `rst` asserted after 30 bytes, then "abc" → output identical to the "abc" scenario; no block from the aborted message.
